// File: rtl/crypt_load_ctrl.sv
// Load/round sequencer for the nibble-wide encrypt/decrypt datapath.
// Optional abort input enabled by defining CRYPT_CTRL_ABORT_EN.
module crypt_load_ctrl #(
  parameter int unsigned KEY_NIBBLES = 2,
  parameter int unsigned ROUNDS      = 4,
  localparam int unsigned RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   Start,
  input  logic                   Mode,
  input  logic                   In_valid,
`ifdef CRYPT_CTRL_ABORT_EN
  input  logic                   Abort,
`endif
  output logic                   In_ready,
  output logic [KEY_NIBBLES-1:0] Ce_key,
  output logic                   Ce_data,
  output logic                   Ce_state,
  output logic                   Ce_out,
  output logic [RW-1:0]          Round,
  output logic                   Mode_q,
  output logic                   Busy,
  output logic                   Done
);

  localparam int unsigned KW = (KEY_NIBBLES > 1) ? $clog2(KEY_NIBBLES) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_KEY  = 3'd1,
    LOAD_DATA = 3'd2,
    ROUND     = 3'd3,
    WRITE     = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [RW-1:0] round_q, round_d;
  logic          mode_q, mode_d;
  logic          abort_c;
  logic [RW-1:0] round_last_c;

`ifdef CRYPT_CTRL_ABORT_EN
  assign abort_c = Abort;
`else
  assign abort_c = 1'b0;
`endif

  // Final round index depends on direction: decrypt counts down to zero.
  assign round_last_c = mode_q ? '0 : RW'(ROUNDS - 1);

  // State and operation context registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      k_q     <= '0;
      round_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      round_q <= round_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state and clock-enable decode.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    round_d  = round_q;
    mode_d   = mode_q;
    In_ready = 1'b0;
    Ce_key   = '0;
    Ce_data  = 1'b0;
    Ce_state = 1'b0;
    Ce_out   = 1'b0;
    Done     = 1'b0;
    Busy     = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = LOAD_KEY;
          mode_d  = Mode;
          k_d     = '0;
        end
      end
      LOAD_KEY: begin
        In_ready = 1'b1;
        if (In_valid) begin
          Ce_key = KEY_NIBBLES'(1) << k_q;
          k_d    = k_q + KW'(1);
          if (k_q == KW'(KEY_NIBBLES - 1)) state_d = LOAD_DATA;
        end
      end
      LOAD_DATA: begin
        In_ready = 1'b1;
        if (In_valid) begin
          Ce_data = 1'b1;
          state_d = ROUND;
          round_d = mode_q ? RW'(ROUNDS - 1) : '0;
        end
      end
      ROUND: begin
        Ce_state = 1'b1;
        if (round_q == round_last_c) state_d = WRITE;
        else if (mode_q)             round_d = round_q - RW'(1);
        else                         round_d = round_q + RW'(1);
      end
      WRITE: begin
        Ce_out  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort squashes this cycle's transfers; round and mode are left as they are.
    if (abort_c && (state_q != IDLE)) begin
      In_ready = 1'b0;
      Ce_key   = '0;
      Ce_data  = 1'b0;
      Ce_state = 1'b0;
      Ce_out   = 1'b0;
      state_d  = IDLE;
      k_d      = k_q;
      round_d  = round_q;
    end
  end

  assign Round  = round_q;
  assign Mode_q = mode_q;

endmodule
